pll_reset_sequencer: RTL

Reset/clock-bring-up controller between the board reference clock, the system PLL and the core. It runs on the reference clock and drives the PLL reset. It waits for a stable PLL lock, then holds the core in reset for a fixed time before releasing it. It retries the PLL on lock timeout, re-sequences on lock loss, and reports status for debug.

---
 rtl/pll_reset_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Reference-clock bring-up controller: pulses the PLL reset, waits for a stable
// synchronized lock, then holds and releases the core reset. Retries on timeout.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CORE_RST_HOLD       = 64,
  parameter int MAX_RETRIES         = 3,
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic               sys_clock,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               core_reset,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count,
  output logic               lock_fail
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > CORE_RST_HOLD) ? LOCK_STABLE_CYCLES : CORE_RST_HOLD;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(CORE_RST_HOLD - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         loss_q, loss_d, loss_inc;
  logic               sync1_q, lock_sync_q;
  logic               pll_rst_q, pll_rst_d;
  logic               core_reset_q, core_reset_d;
  logic               lock_fail_q, lock_fail_d;

  // Two-flop synchronizer for the asynchronous raw lock
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      sync1_q     <= pll_lock;
      lock_sync_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    loss_inc = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

    case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout
        if (lock_sync_q) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_PLL_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABILIZE: begin
        if (!lock_sync_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!lock_sync_q) begin
          loss_d  = loss_inc;
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_sync_q) begin
          loss_d  = loss_inc;
          state_d = ST_PLL_RESET;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge
    pll_rst_d    = (state_d == ST_PLL_RESET);
    core_reset_d = (state_d != ST_RUN);
    lock_fail_d  = lock_fail_q | (state_d == ST_FAIL);
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PLL_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      lock_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_rst_q    <= pll_rst_d;
      core_reset_q <= core_reset_d;
      lock_fail_q  <= lock_fail_d;
    end
  end

  assign state           = state_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign pll_rst         = pll_rst_q;
  assign core_reset      = core_reset_q;
  assign lock_fail       = lock_fail_q;

endmodule
